sorted_drain: RTL and testbench
===============================

# sorted_drain

Read-side companion to the systolic sorter. Once the sorter reports that its last input has passed through the array, this block walks the sorter's address-indexed read port from index 0 (smallest) upward and streams the entries out in ascending key order on a valid/ready interface. It stops at the first invalid entry or at a runtime limit, and marks the final beat. Its consumer is the downstream pair-processing stage (union/merge of id pairs), which needs the K smallest entries in order.

## Interface
Parameters:
- ELEMENTS, 64, depth of the attached sorter
- BIT_WIDTH, 32, key width
- METADATA_TYPE, id_pair_s, per-entry payload type
- ADDRESS_WIDTH, $clog2(ELEMENTS), localparam, sorter read-address width
- CNT_WIDTH, $clog2(ELEMENTS+1), localparam, width of counts and limit

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- s_last  in  1  sorter out_last (latched level; high means array has settled)
- s_address  out  ADDRESS_WIDTH  sorter read address
- s_valid  in  1  sorter entry valid at s_address (combinational)
- s_data  in  BIT_WIDTH  sorter key at s_address
- s_metadata  in  METADATA_TYPE  sorter payload at s_address
- limit  in  CNT_WIDTH  maximum beats to emit; sampled at start; 0 or >ELEMENTS means ELEMENTS
- m_valid  out  1  output beat valid
- m_ready  in  1  consumer accepts beat
- m_data  out  BIT_WIDTH  key
- m_metadata  out  METADATA_TYPE  payload
- m_index  out  CNT_WIDTH  rank of the beat, 0-based
- m_last  out  1  final beat of the drain
- done  out  1  level; the drain is complete and the output register is empty
- count  out  CNT_WIDTH  beats accepted so far in this drain

## Operation
- Internal state: addr (CNT_WIDTH bits); prefetch register P = {valid, data, meta, index}; output register O = {m_*}; latched limit L.
- s_address = addr[ADDRESS_WIDTH-1:0]. When addr==ELEMENTS, the value read is ignored.
- FSM states: IDLE, PRIME, STREAM, DONE.
- IDLE: addr=0, P and O empty. If s_last=1, latch L and go to PRIME.
- PRIME (exactly 1 cycle): s_address=0. P <= entry 0; addr <= 1. If s_valid=0, go to DONE with no beats. Otherwise go to STREAM.
- STREAM: load O when (!m_valid || m_ready).
  - On a load, O <= P and m_last <= (addr==L) || !s_valid. The read at addr is the lookahead.
  - On a load with m_last=0: P <= entry addr, P.index <= addr, addr <= addr+1.
  - On a load with m_last=1: go to DONE. P is not reloaded.
  - With no load, all registers hold.
- DONE: done = !m_valid. When O's beat is accepted, m_valid falls and done rises. Return to IDLE when s_last=0 (sorter reset), after which a new drain is possible.
- count increments on each m_valid && m_ready and clears on the IDLE→PRIME transition.
- Output obeys stream rules: once m_valid=1, m_data, m_metadata, m_index and m_last are stable until accepted. m_valid never drops without a handshake, except on rst.
- Sorter contents must not change while the drain runs (s_last high guarantees this).

## Timing
- Reset values: m_valid=0, m_last=0, m_index=0, m_data=0, m_metadata=0, done=0, count=0, s_address=0, state=IDLE.
- Let s_last be sampled high in IDLE at cycle 0:
  - PRIME is cycle 1.
  - P is valid at cycle 2.
  - The first m_valid is high at cycle 3.
- With m_ready held high, throughput is 1 beat/cycle with no bubbles. N beats end with m_last at cycle 3+N-1. done rises the cycle after the last handshake.
- Empty sorter (entry 0 invalid): no beats; done=1 at cycle 2.
- L=1: a single beat with m_last=1.
- Full sorter with L=ELEMENTS: m_last is forced by addr==L; the out-of-range read is ignored.
- Backpressure: while m_ready=0, addr and P freeze, and s_address stays constant.
- rst mid-drain: all outputs return to reset values on the next edge; any in-flight beat is dropped.
- s_last falling before DONE is a protocol error. Required response: finish the current beat, then go to IDLE at the next load opportunity, with no m_last guarantee.

## Structure
- Shared package sorter_pkg holds:
  - INDEX_WIDTH
  - id_pair_s
  - the FSM state enum
- The sorter moves to that package import. It must not redefine id_pair_s.
- One natural sub-module: stream_reg_slice. It is the parameterised single-entry output register with valid/ready, loaded by the FSM and reusable by other stream stages.

## Test plan
- Sorter holds keys {5,9,12} in entries 0–2, entry 3 invalid; limit=0; m_ready=1 → beats 5,9,12 with m_index 0,1,2; m_last on 12; first m_valid 3 cycles after s_last; done then count=3.
- Full 64-entry sorter, limit=10 → exactly 10 beats (entries 0–9), m_last on index 9, count=10.
- Empty sorter (s_valid=0 at address 0) → no m_valid ever; done=1 two cycles after s_last.
- Keys {1,2,3,4}; m_ready toggles 1,0,0,1,... → order preserved; O stable during stalls; s_address frozen while stalled; no duplicate or lost beat.
- rst asserted while the 2nd of 4 beats is pending → next cycle m_valid=0, count=0, state IDLE.
- Restart: s_last drops, sorter refilled with {7}, s_last rises → one beat, 7, with m_last=1 and m_index=0.

Source files
------------

// File: rtl/sorter_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : sorter_pkg
//  Purpose   : Types shared by the systolic sorter and its read-side drain:
//              id-pair payload, index width and the drain FSM state encoding.
//  Revision  : 1.0  initial release
// ============================================================================
package sorter_pkg;

   localparam int INDEX_WIDTH = 16;

   // Payload carried alongside each key: a pair of element ids.
   typedef struct packed {
      logic [INDEX_WIDTH-1:0] id_a;
      logic [INDEX_WIDTH-1:0] id_b;
   } id_pair_s;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PRIME  = 2'd1,
      ST_STREAM = 2'd2,
      ST_DONE   = 2'd3
   } drain_state_e;

endpackage : sorter_pkg
`default_nettype wire

// File: rtl/sorted_drain_if.sv
`default_nettype none
// ============================================================================
//  Interface : sorted_drain_if
//  Purpose   : Valid/ready output stream of the sorted drain.
//  Signals   : m_valid, m_ready, m_data (key), m_metadata (payload),
//              m_index (0-based rank), m_last (final beat)
//  Modports  : master (drain side), slave (consumer side)
//  Revision  : 1.0  initial release
// ============================================================================
interface sorted_drain_if
   import sorter_pkg::*;
#(
   parameter int  BIT_WIDTH     = 32,
   parameter int  CNT_WIDTH     = 7,
   parameter type METADATA_TYPE = id_pair_s
);
   logic                 m_valid;
   logic                 m_ready;
   logic [BIT_WIDTH-1:0] m_data;
   METADATA_TYPE         m_metadata;
   logic [CNT_WIDTH-1:0] m_index;
   logic                 m_last;

   modport master (
      output m_valid, m_data, m_metadata, m_index, m_last,
      input  m_ready
   );

   modport slave (
      input  m_valid, m_data, m_metadata, m_index, m_last,
      output m_ready
   );
endinterface : sorted_drain_if
`default_nettype wire

// File: rtl/stream_reg_slice.sv
`default_nettype none
// ============================================================================
//  Module    : stream_reg_slice
//  Purpose   : Single-entry registered output stage with valid/ready.
//              The owner asserts load_i only when the slot is free or being
//              drained this cycle (!valid_o || ready_i). Without a load, an
//              accepted beat empties the slot.
//  Ports     : clk, rst     clock, synchronous active-high reset
//              load_i       capture data_i into the slot
//              data_i       payload to capture
//              ready_i      consumer accepts the current beat
//              valid_o      slot holds a beat
//              data_o       held payload (stable while valid_o && !ready_i)
//  Revision  : 1.0  initial release
// ============================================================================
module stream_reg_slice #(
   parameter type PAYLOAD_T = logic [31:0]
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     load_i,
   input  PAYLOAD_T data_i,
   input  logic     ready_i,
   output logic     valid_o,
   output PAYLOAD_T data_o
);

   logic     valid_q;
   PAYLOAD_T data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule : stream_reg_slice
`default_nettype wire

// File: rtl/sorted_drain.sv
`default_nettype none
// ============================================================================
//  Module    : sorted_drain
//  Purpose   : Once the sorter has settled (s_last high), walk its read port
//              from entry 0 upward and stream entries out in ascending order,
//              stopping at the first invalid entry or at the latched limit.
//  Ports     : clk, rst          clock, synchronous active-high reset
//              s_last            sorter settled (level)
//              s_address         sorter read address
//              s_valid/s_data/
//              s_metadata        sorter entry at s_address (combinational)
//              limit             max beats, sampled at start (0 / >ELEMENTS
//                                means ELEMENTS)
//              m_stream          output stream (master modport)
//              done              drain complete and output register empty
//              count             beats accepted in this drain
//  Revision  : 1.0  initial release
// ============================================================================
module sorted_drain
   import sorter_pkg::*;
#(
   parameter int  ELEMENTS      = 64,
   parameter int  BIT_WIDTH     = 32,
   parameter type METADATA_TYPE = id_pair_s,
   localparam int ADDRESS_WIDTH = $clog2(ELEMENTS),
   localparam int CNT_WIDTH     = $clog2(ELEMENTS + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s_last,
   output logic [ADDRESS_WIDTH-1:0] s_address,
   input  logic                     s_valid,
   input  logic [BIT_WIDTH-1:0]     s_data,
   input  METADATA_TYPE             s_metadata,
   input  logic [CNT_WIDTH-1:0]     limit,
   sorted_drain_if.master           m_stream,
   output logic                     done,
   output logic [CNT_WIDTH-1:0]     count
);

   localparam logic [CNT_WIDTH-1:0] C_ELEMENTS = CNT_WIDTH'(ELEMENTS);
   localparam logic [CNT_WIDTH-1:0] C_ONE      = CNT_WIDTH'(1);

   typedef struct packed {
      logic [BIT_WIDTH-1:0] data;
      METADATA_TYPE         meta;
      logic [CNT_WIDTH-1:0] index;
      logic                 last;
   } beat_t;

   drain_state_e         state_q, state_d;
   logic [CNT_WIDTH-1:0] addr_q, addr_d;
   logic [CNT_WIDTH-1:0] lim_q, lim_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;

   // Prefetch register: entry already read, waiting for the output slot.
   logic                 p_valid_q, p_valid_d;
   logic [BIT_WIDTH-1:0] p_data_q, p_data_d;
   METADATA_TYPE         p_meta_q, p_meta_d;
   logic [CNT_WIDTH-1:0] p_index_q, p_index_d;

   logic                 out_load;
   logic                 out_valid;
   beat_t                out_beat;
   beat_t                beat_d;
   logic                 can_load;
   logic                 handshake;
   logic                 addr_oob;
   logic                 last_beat;
   logic [CNT_WIDTH-1:0] lim_eff;

   assign s_address = addr_q[ADDRESS_WIDTH-1:0];
   assign handshake = out_valid && m_stream.m_ready;
   assign can_load  = !out_valid || m_stream.m_ready;
   // Reading past the array wraps the address; such a read is never trusted.
   assign addr_oob  = (addr_q >= C_ELEMENTS);
   assign lim_eff   = ((limit == '0) || (limit > C_ELEMENTS)) ? C_ELEMENTS : limit;
   // The read at addr is the lookahead: the beat moving out of P is final if
   // the limit is reached or the next entry does not exist.
   assign last_beat = (addr_q == lim_q) || !s_valid || addr_oob;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         lim_q     <= '0;
         count_q   <= '0;
         p_valid_q <= 1'b0;
         p_data_q  <= '0;
         p_meta_q  <= '0;
         p_index_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         lim_q     <= lim_d;
         count_q   <= count_d;
         p_valid_q <= p_valid_d;
         p_data_q  <= p_data_d;
         p_meta_q  <= p_meta_d;
         p_index_q <= p_index_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      lim_d     = lim_q;
      count_d   = handshake ? (count_q + C_ONE) : count_q;
      p_valid_d = p_valid_q;
      p_data_d  = p_data_q;
      p_meta_d  = p_meta_q;
      p_index_d = p_index_q;
      out_load  = 1'b0;
      beat_d.data  = p_data_q;
      beat_d.meta  = p_meta_q;
      beat_d.index = p_index_q;
      beat_d.last  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            addr_d    = '0;
            p_valid_d = 1'b0;
            if (s_last) begin
               lim_d   = lim_eff;
               count_d = '0;
               state_d = ST_PRIME;
            end
         end

         ST_PRIME: begin
            p_valid_d = s_valid;
            p_data_d  = s_data;
            p_meta_d  = s_metadata;
            p_index_d = '0;
            addr_d    = C_ONE;
            state_d   = s_valid ? ST_STREAM : ST_DONE;
         end

         ST_STREAM: begin
            if (can_load) begin
               if (!s_last) begin
                  // Sorter was reset under us: let the current beat go and
                  // abandon the drain without issuing anything further.
                  p_valid_d = 1'b0;
                  addr_d    = '0;
                  state_d   = ST_IDLE;
               end else begin
                  out_load    = 1'b1;
                  beat_d.last = last_beat;
                  if (last_beat) begin
                     state_d = ST_DONE;
                  end else begin
                     p_valid_d = 1'b1;
                     p_data_d  = s_data;
                     p_meta_d  = s_metadata;
                     p_index_d = addr_q;
                     addr_d    = addr_q + C_ONE;
                  end
               end
            end
         end

         ST_DONE: begin
            // Wait for the final beat to leave before rearming, so IDLE
            // always starts with an empty output register.
            if (!s_last && !out_valid) begin
               addr_d    = '0;
               p_valid_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   stream_reg_slice #(
      .PAYLOAD_T (beat_t)
   ) u_out_slice (
      .clk     (clk),
      .rst     (rst),
      .load_i  (out_load),
      .data_i  (beat_d),
      .ready_i (m_stream.m_ready),
      .valid_o (out_valid),
      .data_o  (out_beat)
   );

   assign m_stream.m_valid    = out_valid;
   assign m_stream.m_data     = out_beat.data;
   assign m_stream.m_metadata = out_beat.meta;
   assign m_stream.m_index    = out_beat.index;
   assign m_stream.m_last     = out_beat.last;

   assign done  = (state_q == ST_DONE) && !out_valid;
   assign count = count_q;

endmodule : sorted_drain
`default_nettype wire

// File: tb/tb_sorted_drain.sv
`default_nettype none
// ============================================================================
//  Module    : tb_sorted_drain
//  Purpose   : Self-checking bench for sorted_drain with a behavioural
//              sorter read port (arrays indexed by s_address).
//  Revision  : 1.0  initial release
// ============================================================================
module tb_sorted_drain;
   import sorter_pkg::*;

   localparam int ELEMENTS  = 64;
   localparam int BIT_WIDTH = 32;
   localparam int CNT_WIDTH = 7;
   localparam int AW        = 6;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 s_last;
   logic [AW-1:0]        s_address;
   logic                 s_valid;
   logic [BIT_WIDTH-1:0] s_data;
   id_pair_s             s_metadata;
   logic [CNT_WIDTH-1:0] limit;
   logic                 done;
   logic [CNT_WIDTH-1:0] count;

   sorted_drain_if #(
      .BIT_WIDTH     (BIT_WIDTH),
      .CNT_WIDTH     (CNT_WIDTH),
      .METADATA_TYPE (id_pair_s)
   ) bus ();

   sorted_drain #(
      .ELEMENTS      (ELEMENTS),
      .BIT_WIDTH     (BIT_WIDTH),
      .METADATA_TYPE (id_pair_s)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .s_last     (s_last),
      .s_address  (s_address),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_metadata (s_metadata),
      .limit      (limit),
      .m_stream   (bus),
      .done       (done),
      .count      (count)
   );

   always #5 clk = ~clk;

   // Sorter contents model
   logic [BIT_WIDTH-1:0] mem_key  [ELEMENTS];
   logic                 mem_vld  [ELEMENTS];
   id_pair_s             mem_meta [ELEMENTS];

   assign s_valid    = mem_vld[s_address];
   assign s_data     = mem_key[s_address];
   assign s_metadata = mem_meta[s_address];

   // Beats captured at handshakes
   logic [BIT_WIDTH-1:0] got_key  [128];
   logic [CNT_WIDTH-1:0] got_idx  [128];
   logic                 got_last [128];
   id_pair_s             got_meta [128];

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int n_entries;
      int lim;
      int exp_beats;
      int exp_done_cyc;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic fill_seq(input int n, input int base, input int step);
      for (int i = 0; i < ELEMENTS; i++) begin
         mem_vld[i]  = (i < n);
         mem_key[i]  = (i < n) ? 32'(base + step * i) : (32'hDEAD_0000 + 32'(i));
         mem_meta[i] = '{id_a: 16'(i), id_b: 16'(1000 + i)};
      end
   endtask

   // Raise s_last and run until done (or budget). mode 0: ready always 1;
   // mode 1: ready pattern 1,0,0 repeating. Cycle 1 is the PRIME cycle.
   task automatic drain(input int mode, input int max_cyc, output int nbeats,
                        output int first_cyc, output int done_cyc,
                        output int cnt_at_done, output int timed_out);
      int                   cyc;
      logic                 stall;
      logic [BIT_WIDTH-1:0] pd;
      logic [CNT_WIDTH-1:0] pi;
      logic                 pl;
      id_pair_s             pm;
      logic [AW-1:0]        pa;
      nbeats = 0; first_cyc = -1; done_cyc = -1; cnt_at_done = -1; timed_out = 0;
      cyc = 0; stall = 1'b0; pd = '0; pi = '0; pl = 1'b0; pm = '0; pa = '0;
      @(negedge clk);
      s_last = 1'b1;
      bus.m_ready = 1'b1;
      while (done_cyc < 0 && timed_out == 0) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         bus.m_ready = (mode == 0) ? 1'b1 : (((cyc - 1) % 3) == 0);
         if (stall) begin
            check("stall_valid", 64'(bus.m_valid), 64'd1);
            check("stall_data", 64'(bus.m_data), 64'(pd));
            check("stall_index", 64'(bus.m_index), 64'(pi));
            check("stall_last", 64'(bus.m_last), 64'(pl));
            check("stall_meta", 64'(bus.m_metadata), 64'(pm));
            check("stall_addr", 64'(s_address), 64'(pa));
         end
         if (bus.m_valid && first_cyc < 0) first_cyc = cyc;
         if (bus.m_valid && bus.m_ready) begin
            if (nbeats < 128) begin
               got_key[nbeats]  = bus.m_data;
               got_idx[nbeats]  = bus.m_index;
               got_last[nbeats] = bus.m_last;
               got_meta[nbeats] = bus.m_metadata;
            end
            nbeats++;
         end
         stall = bus.m_valid && !bus.m_ready;
         pd = bus.m_data; pi = bus.m_index; pl = bus.m_last; pm = bus.m_metadata;
         pa = s_address;
         if (done) begin
            done_cyc    = cyc;
            cnt_at_done = int'(count);
         end
         if (cyc >= max_cyc) timed_out = 1;
      end
   endtask

   task automatic verify_beats(input int nbeats, input int exp_beats);
      for (int r = 0; r < exp_beats && r < nbeats && r < 128; r++) begin
         check("beat_key", 64'(got_key[r]), 64'(mem_key[r]));
         check("beat_index", 64'(got_idx[r]), 64'(r));
         check("beat_meta", 64'(got_meta[r]), 64'(mem_meta[r]));
         check("beat_last", 64'(got_last[r]), 64'(r == exp_beats - 1));
      end
   endtask

   task automatic end_drain();
      @(negedge clk);
      s_last = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rearm_done", 64'(done), 64'd0);
      check("rearm_valid", 64'(bus.m_valid), 64'd0);
   endtask

   initial begin
      int nb, fc, dc, cd, to;

      vecs[0] = '{64,  10, 10, 13};
      vecs[1] = '{ 0,   0,  0,  2};
      vecs[2] = '{ 5,   1,  1,  4};
      vecs[3] = '{64,   0, 64, 67};
      vecs[4] = '{64,  64, 64, 67};
      vecs[5] = '{64, 100, 64, 67};
      vecs[6] = '{ 5,   5,  5,  8};
      vecs[7] = '{ 5,   6,  5,  8};
      vecs[8] = '{10,   3,  3,  6};

      rst = 1'b1; s_last = 1'b0; limit = '0; bus.m_ready = 1'b0;
      fill_seq(0, 0, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 64'(bus.m_valid), 64'd0);
      check("rst_last", 64'(bus.m_last), 64'd0);
      check("rst_index", 64'(bus.m_index), 64'd0);
      check("rst_data", 64'(bus.m_data), 64'd0);
      check("rst_meta", 64'(bus.m_metadata), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_addr", 64'(s_address), 64'd0);
      rst = 1'b0;

      // Keys {5,9,12}, entry 3 invalid, limit 0
      fill_seq(0, 0, 0);
      mem_vld[0] = 1'b1; mem_key[0] = 32'd5;
      mem_vld[1] = 1'b1; mem_key[1] = 32'd9;
      mem_vld[2] = 1'b1; mem_key[2] = 32'd12;
      limit = 7'd0;
      drain(0, 300, nb, fc, dc, cd, to);
      check("k3_timeout", 64'(to), 64'd0);
      check("k3_beats", 64'(nb), 64'd3);
      check("k3_first", 64'(fc), 64'd3);
      check("k3_done_cyc", 64'(dc), 64'd6);
      check("k3_count", 64'(cd), 64'd3);
      check("k3_key0", 64'(got_key[0]), 64'd5);
      check("k3_key2", 64'(got_key[2]), 64'd12);
      verify_beats(nb, 3);
      end_drain();

      for (int v = 0; v < 9; v++) begin
         fill_seq(vecs[v].n_entries, 100, 3);
         limit = 7'(vecs[v].lim);
         drain(0, 300, nb, fc, dc, cd, to);
         check("vec_timeout", 64'(to), 64'd0);
         check("vec_beats", 64'(nb), 64'(vecs[v].exp_beats));
         check("vec_done_cyc", 64'(dc), 64'(vecs[v].exp_done_cyc));
         check("vec_count", 64'(cd), 64'(vecs[v].exp_beats));
         if (vecs[v].exp_beats > 0) check("vec_first", 64'(fc), 64'd3);
         else check("vec_no_valid", 64'(fc), 64'hFFFF_FFFF_FFFF_FFFF);
         verify_beats(nb, vecs[v].exp_beats);
         end_drain();
      end

      // Backpressure: ready pattern 1,0,0,...
      fill_seq(4, 1, 1);
      limit = 7'd0;
      drain(1, 300, nb, fc, dc, cd, to);
      check("bp_timeout", 64'(to), 64'd0);
      check("bp_beats", 64'(nb), 64'd4);
      check("bp_count", 64'(cd), 64'd4);
      check("bp_first", 64'(fc), 64'd3);
      verify_beats(nb, 4);
      end_drain();

      // Reset while the 2nd of 4 beats is pending
      fill_seq(4, 1, 1);
      limit = 7'd0;
      @(negedge clk);
      s_last = 1'b1;
      bus.m_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("mr_first_valid", 64'(bus.m_valid), 64'd1);
      check("mr_first_index", 64'(bus.m_index), 64'd0);
      @(posedge clk);
      @(negedge clk);
      bus.m_ready = 1'b0;
      check("mr_pend_valid", 64'(bus.m_valid), 64'd1);
      check("mr_pend_index", 64'(bus.m_index), 64'd1);
      check("mr_pend_data", 64'(bus.m_data), 64'd2);
      check("mr_pend_count", 64'(count), 64'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mr_valid", 64'(bus.m_valid), 64'd0);
      check("mr_count", 64'(count), 64'd0);
      check("mr_done", 64'(done), 64'd0);
      check("mr_addr", 64'(s_address), 64'd0);
      check("mr_index", 64'(bus.m_index), 64'd0);
      check("mr_data", 64'(bus.m_data), 64'd0);
      rst = 1'b0;
      s_last = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("mr_idle_valid", 64'(bus.m_valid), 64'd0);

      // Restart with refilled sorter {7}
      fill_seq(1, 7, 0);
      limit = 7'd0;
      drain(0, 300, nb, fc, dc, cd, to);
      check("rs_timeout", 64'(to), 64'd0);
      check("rs_beats", 64'(nb), 64'd1);
      check("rs_key", 64'(got_key[0]), 64'd7);
      check("rs_last", 64'(got_last[0]), 64'd1);
      check("rs_index", 64'(got_idx[0]), 64'd0);
      check("rs_done_cyc", 64'(dc), 64'd4);
      check("rs_count", 64'(cd), 64'd1);
      end_drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_sorted_drain
`default_nettype wire
